// File: rtl/response_resolver_pkg.sv
// cap_pkg: array geometry shared with the compare and cell blocks, plus the resolver state encoding.
`default_nettype none

package cap_pkg;

  localparam int CAP_WORDS = 100;
  localparam int CAP_WIDTH = 32;
  localparam int CAP_IDX_W = 7;

  typedef enum logic [2:0] {
    RS_IDLE    = 3'd0,
    RS_SCAN    = 3'd1,
    RS_FETCH   = 3'd2,
    RS_PRESENT = 3'd3,
    RS_DONE    = 3'd4
  } resolver_state_t;

endpackage

`default_nettype wire

// File: rtl/response_resolver_if.sv
// response_resolver_if: search-result capture, cell read-back and responder output stream.
`default_nettype none

interface response_resolver_if
  import cap_pkg::*;
#(
  parameter int WORDS = CAP_WORDS,
  parameter int WIDTH = CAP_WIDTH,
  parameter int IDX_W = CAP_IDX_W
);

  logic             start;
  logic [WORDS-1:0] match_lines;
  logic [WORDS-1:0] select_lines;
  logic [WIDTH-1:0] read_lines;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_index;
  logic             done;
  logic [IDX_W:0]   match_count;

  modport master (
    output start, match_lines, read_lines, out_ready,
    input  select_lines, busy, out_valid, out_data, out_index, done, match_count
  );

  modport slave (
    input  start, match_lines, read_lines, out_ready,
    output select_lines, busy, out_valid, out_data, out_index, done, match_count
  );

endinterface

`default_nettype wire

// File: rtl/response_resolver_first_responder.sv
// first_responder: lowest set tag index, its one-hot and an any-set flag (purely combinational).
`default_nettype none

module first_responder #(
  parameter int WORDS = 100,
  parameter int IDX_W = 7
) (
  input  logic [WORDS-1:0] tags_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [WORDS-1:0] onehot_o,
  output logic             any_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = tags_i & (~tags_i + {{(WORDS-1){1'b0}}, 1'b1});
  assign any_o    = |tags_i;

  always_comb begin
    idx_o = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (tags_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/response_resolver.sv
// response_resolver: walks latched match tags lowest-first and streams each word with its index.
// Define RESP_COUNT_EN to latch popcount(match_lines) on match_count at start; otherwise it is 0.
`default_nettype none

module response_resolver
  import cap_pkg::*;
#(
  parameter int WORDS = CAP_WORDS,
  parameter int WIDTH = CAP_WIDTH,
  parameter int IDX_W = CAP_IDX_W
) (
  input logic                CLK,
  input logic                RST,
  response_resolver_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'(RS_IDLE);
  localparam logic [2:0] ST_SCAN    = 3'(RS_SCAN);
  localparam logic [2:0] ST_FETCH   = 3'(RS_FETCH);
  localparam logic [2:0] ST_PRESENT = 3'(RS_PRESENT);
  localparam logic [2:0] ST_DONE    = 3'(RS_DONE);

  logic [2:0]       state_q, state_d;
  logic [WORDS-1:0] tags_q, tags_d;
  logic [WORDS-1:0] sel_oh_q, sel_oh_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] index_q, index_d;

  logic [WORDS-1:0] first_oh;
  logic [IDX_W-1:0] first_idx;
  logic             first_any;

  first_responder #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_first (
    .tags_i   (tags_q),
    .idx_o    (first_idx),
    .onehot_o (first_oh),
    .any_o    (first_any)
  );

  always_comb begin
    state_d   = state_q;
    tags_d    = tags_q;
    sel_oh_d  = sel_oh_q;
    sel_idx_d = sel_idx_q;
    data_d    = data_q;
    index_d   = index_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          tags_d  = bus.match_lines;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!first_any) begin
          state_d = ST_DONE;
        end else begin
          sel_idx_d = first_idx;
          sel_oh_d  = first_oh;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        data_d  = bus.read_lines;
        index_d = sel_idx_q;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.out_ready) begin
          tags_d  = tags_q & ~sel_oh_q;
          state_d = ST_SCAN;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      tags_q    <= '0;
      sel_oh_q  <= '0;
      sel_idx_q <= '0;
      data_q    <= '0;
      index_q   <= '0;
    end else begin
      state_q   <= state_d;
      tags_q    <= tags_d;
      sel_oh_q  <= sel_oh_d;
      sel_idx_q <= sel_idx_d;
      data_q    <= data_d;
      index_q   <= index_d;
    end
  end

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.out_valid    = (state_q == ST_PRESENT);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.select_lines = (state_q == ST_FETCH) ? sel_oh_q : '0;
  assign bus.out_data     = data_q;
  assign bus.out_index    = index_q;

`ifdef RESP_COUNT_EN
  logic [IDX_W:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (state_q == ST_IDLE && bus.start) begin
      count_d = '0;
      for (int i = 0; i < WORDS; i++) begin
        count_d = count_d + {{IDX_W{1'b0}}, bus.match_lines[i]};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  assign bus.match_count = count_q;
`else
  assign bus.match_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_response_resolver.sv
// tb_response_resolver: directed vector table plus hand sequences for stall, reset and start-collision cases.
`default_nettype none

module tb_response_resolver;
  import cap_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  response_resolver_if bus ();

  response_resolver dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Cell array model: selected word reads back as index*7.
  always_comb begin
    bus.read_lines = '0;
    for (int i = 0; i < CAP_WORDS; i++) begin
      if (bus.select_lines[i]) bus.read_lines = 32'(i * 7);
    end
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [99:0] ml;
    int          exp_cnt;
    bit          disturb;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [99:0] oh;
    int exp_mc;
`ifdef RESP_COUNT_EN
    exp_mc = v.exp_cnt;
`else
    exp_mc = 0;
`endif
    bus.match_lines = v.ml;
    bus.start       = 1'b1;
    bus.out_ready   = 1'b1;
    step();
    bus.start = v.disturb;
    if (v.disturb) bus.match_lines = ~v.ml;
    chk("busy_after_start", bus.busy, 1);
    chk("match_count", bus.match_count, exp_mc);
    for (int i = 0; i < CAP_WORDS; i++) begin
      if (v.ml[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
        step();
        chk("select_fetch", bus.select_lines, oh);
        chk("valid_in_fetch", bus.out_valid, 0);
        step();
        chk("valid_present", bus.out_valid, 1);
        chk("index", bus.out_index, i);
        chk("data", bus.out_data, i * 7);
        chk("select_present", bus.select_lines, 0);
        step();
        chk("valid_after_accept", bus.out_valid, 0);
      end
    end
    step();
    chk("done_pulse", bus.done, 1);
    chk("valid_at_done", bus.out_valid, 0);
    bus.start = 1'b0;
    step();
    chk("done_cleared", bus.done, 0);
    chk("busy_end", bus.busy, 0);
    chk("match_count_hold", bus.match_count, exp_mc);
  endtask

  initial begin
    vecs[0].ml = '0; vecs[0].ml[3] = 1'b1; vecs[0].ml[17] = 1'b1; vecs[0].ml[99] = 1'b1;
    vecs[0].exp_cnt = 3;   vecs[0].disturb = 1'b0;
    vecs[1].ml = '0;
    vecs[1].exp_cnt = 0;   vecs[1].disturb = 1'b0;
    vecs[2].ml = '0; vecs[2].ml[0] = 1'b1; vecs[2].ml[1] = 1'b1; vecs[2].ml[2] = 1'b1;
    vecs[2].exp_cnt = 3;   vecs[2].disturb = 1'b0;
    vecs[3].ml = '0; vecs[3].ml[10] = 1'b1; vecs[3].ml[20] = 1'b1;
    vecs[3].exp_cnt = 2;   vecs[3].disturb = 1'b1;
    vecs[4].ml = '1;
    vecs[4].exp_cnt = 100; vecs[4].disturb = 1'b0;
    vecs[5].ml = '0; vecs[5].ml[99] = 1'b1;
    vecs[5].exp_cnt = 1;   vecs[5].disturb = 1'b1;

    RST             = 1'b1;
    bus.start       = 1'b0;
    bus.match_lines = '0;
    bus.out_ready   = 1'b0;
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_index", bus.out_index, 0);
    chk("rst_select", bus.select_lines, 0);
    chk("rst_count", bus.match_count, 0);
    RST = 1'b0;
    step();

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Downstream stall: word 5 must sit unchanged until ready returns.
    bus.match_lines = '0;
    bus.match_lines[5] = 1'b1;
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_index", bus.out_index, 5);
      chk("stall_data", bus.out_data, 35);
      chk("stall_select", bus.select_lines, 0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("stall_accept", bus.out_valid, 0);
    step();
    chk("stall_done", bus.done, 1);
    step();
    chk("stall_idle", bus.busy, 0);

    // Reset while presenting index 2 of {2,4}.
    bus.match_lines = '0;
    bus.match_lines[2] = 1'b1;
    bus.match_lines[4] = 1'b1;
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("pre_rst_valid", bus.out_valid, 1);
    chk("pre_rst_index", bus.out_index, 2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_index", bus.out_index, 0);
    chk("mid_rst_count", bus.match_count, 0);
    step();
    chk("mid_rst_stay_idle", bus.busy, 0);
    begin
      vec_t v8;
      v8.ml = '0;
      v8.ml[8] = 1'b1;
      v8.exp_cnt = 1;
      v8.disturb = 1'b0;
      run_vec(v8);
    end

    // Reset and start together: reset wins.
    bus.match_lines = '0;
    bus.match_lines[7] = 1'b1;
    RST = 1'b1;
    bus.start = 1'b1;
    step();
    RST = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy", bus.busy, 0);
    step();
    chk("rst_start_still_idle", bus.busy, 0);
    chk("rst_start_valid", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
